// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the two-port RAM arbiter
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default RAM address and data widths
//   state_t                 : sequencer states IDLE, ACCESS, RESP
//   owner_t                 : port encoding, OWN_CPU = 0, OWN_DBG = 1
// Optional feature macro used by this bundle: ARB_ROUND_ROBIN_EN
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select for the two-port RAM arbiter
// Ports:
//   cpu_req, dbg_req : pending requests
//   last_grant       : port granted most recently (only with ARB_ROUND_ROBIN_EN)
//   valid            : at least one request is pending
//   winner           : selected port (OWN_CPU / OWN_DBG encoding)
// Macro ARB_ROUND_ROBIN_EN: ties go to the port other than last_grant;
// otherwise ties always go to the CPU.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = cpu_req | dbg_req;
        winner = OWN_CPU;
        if (dbg_req && !cpu_req) begin
            winner = OWN_DBG;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (dbg_req && cpu_req && (last_grant == OWN_CPU)) begin
            winner = OWN_DBG;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one synchronous-read RAM between CPU and debug ports
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          : CPU command, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata : CPU accept pulse, read-data pulse, read data
//   dbg_*                          : same set for the debug/loader port
//   mem_addr, mem_write, mem_din   : RAM command (driven from cmd registers)
//   mem_dout                       : RAM read data, valid the cycle after the address
// Macro ARB_ROUND_ROBIN_EN: round-robin tie break instead of CPU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    logic              arb_en;
    logic              accept;
    logic              pick_valid;
    logic              pick_winner;
    owner_t            win;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t            last_grant;
`endif

    mem_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign win    = owner_t'(pick_winner);
    // Arbitration only happens in IDLE and RESP; in ACCESS the granted req
    // is still high and must not be taken as a second command.
    assign accept = arb_en & pick_valid;

    always_comb begin
        state_nxt  = state;
        arb_en     = 1'b0;
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE: begin
                arb_en = 1'b1;
            end
            ACCESS: begin
                cpu_gnt   = (owner == OWN_CPU);
                dbg_gnt   = (owner == OWN_DBG);
                // Reset arriving mid-access must not corrupt the RAM.
                mem_write = cmd_we & ~reset;
                state_nxt = RESP;
            end
            RESP: begin
                arb_en     = 1'b1;
                cpu_rvalid = ~cmd_we & (owner == OWN_CPU);
                dbg_rvalid = ~cmd_we & (owner == OWN_DBG);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (arb_en) begin
            state_nxt = pick_valid ? ACCESS : IDLE;
        end
    end

    // RAM data passes straight through during the rvalid cycle; the
    // registered copy keeps the last delivered word visible afterwards.
    assign cpu_rdata = cpu_rvalid ? mem_dout : cpu_rdata_q;
    assign dbg_rdata = dbg_rvalid ? mem_dout : dbg_rdata_q;

    // The RAM is always addressed from the cmd registers so its inputs
    // stay stable outside the single ACCESS cycle.
    assign mem_addr = cmd_addr;
    assign mem_din  = cmd_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            cmd_we      <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner     <= win;
                cmd_we    <= (win == OWN_DBG) ? dbg_we    : cpu_we;
                cmd_addr  <= (win == OWN_DBG) ? dbg_addr  : cpu_addr;
                cmd_wdata <= (win == OWN_DBG) ? dbg_wdata : cpu_wdata;
            end
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_dout;
            end
            if (dbg_rvalid) begin
                dbg_rdata_q <= mem_dout;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Reset value DBG makes the first tie after reset go to the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= OWN_DBG;
        end else if (accept) begin
            last_grant <= win;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural RAM
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [DW-1:0] mem_din, mem_dout;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears the cycle after the address.
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // One isolated access starting from IDLE.
    task automatic run_single(input bit port, input bit we, input logic [7:0] addr,
                              input logic [15:0] wdata, input logic [15:0] exp, input string tag);
        if (port == 1'b0) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end
        step();
        check({tag, "_gnt"}, {cpu_gnt, dbg_gnt}, port ? 2'b01 : 2'b10);
        check({tag, "_mem_write"}, mem_write, we);
        check({tag, "_mem_addr"}, mem_addr, addr);
        if (we) check({tag, "_mem_din"}, mem_din, wdata);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        step();
        check({tag, "_resp_mem_write"}, mem_write, 1'b0);
        check({tag, "_rvalid"}, {cpu_rvalid, dbg_rvalid}, we ? 2'b00 : (port ? 2'b01 : 2'b10));
        if (!we) check({tag, "_rdata"}, port ? dbg_rdata : cpu_rdata, exp);
        if (we) ref_mem[addr] = wdata;
        step();
        check({tag, "_idle_gnt"}, {cpu_gnt, dbg_gnt}, 2'b00);
    endtask

    initial begin
        bit          cp, dp, ew, w_we, exp_last;
        logic [7:0]  w_addr;
        logic [15:0] w_wdata, exp_cpu_rd, exp_dbg_rd;
        int          sel;

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

        vecs[0] = '{1'b0, 1'b1, 8'd25,  16'hFFE9, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 8'd25,  16'h0000, 16'hFFE9};
        vecs[2] = '{1'b0, 1'b1, 8'd0,   16'h1234, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 8'd0,   16'h0000, 16'h1234};
        vecs[4] = '{1'b1, 1'b1, 8'd200, 16'hBEEF, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 8'd200, 16'h0000, 16'hBEEF};
        vecs[6] = '{1'b1, 1'b0, 8'd25,  16'h0000, 16'hFFE9};
        vecs[7] = '{1'b0, 1'b1, 8'd255, 16'h0001, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 8'd255, 16'h0000, 16'h0001};

        // Reset values
        do_reset();
        check("rst_gnt",       {cpu_gnt, dbg_gnt}, 2'b00);
        check("rst_rvalid",    {cpu_rvalid, dbg_rvalid}, 2'b00);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 16'h0);
        check("rst_dbg_rdata", dbg_rdata, 16'h0);
        check("rst_mem_addr",  mem_addr, 8'h0);
        check("rst_mem_din",   mem_din, 16'h0);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            run_single(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                       vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Back-to-back: new CPU read presented during RESP
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd25;
        step();
        check("b2b_gnt1", cpu_gnt, 1'b1);
        step();
        check("b2b_rvalid1", cpu_rvalid, 1'b1);
        check("b2b_rdata1", cpu_rdata, ref_mem[25]);
        cpu_addr = 8'd0;
        step();
        check("b2b_gnt2", cpu_gnt, 1'b1);
        check("b2b_addr2", mem_addr, 8'd0);
        cpu_req = 1'b0;
        step();
        check("b2b_rvalid2", cpu_rvalid, 1'b1);
        check("b2b_rdata2", cpu_rdata, ref_mem[0]);
        step();

        // Tie: both ports request continuously for 8 accesses
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd25;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd0;
        for (int i = 0; i < 8; i++) begin
            step();
`ifdef ARB_ROUND_ROBIN_EN
            ew = i[0];
`else
            ew = 1'b0;
`endif
            check($sformatf("tie_gnt%0d", i), {cpu_gnt, dbg_gnt}, ew ? 2'b01 : 2'b10);
            if (i == 7) begin
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
            step();
            check($sformatf("tie_rvalid%0d", i), {cpu_rvalid, dbg_rvalid}, ew ? 2'b01 : 2'b10);
            check($sformatf("tie_rdata%0d", i), ew ? dbg_rdata : cpu_rdata, ew ? ref_mem[0] : ref_mem[25]);
        end
        step();
        check("tie_idle", {cpu_gnt, dbg_gnt}, 2'b00);

        // Reset during the ACCESS cycle of a write
        run_single(1'b0, 1'b1, 8'd3, 16'h5555, 16'h0, "pre5555");
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd3; cpu_wdata = 16'hAAAA;
        step();
        check("rstacc_gnt", cpu_gnt, 1'b1);
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        check("rstacc_mem_write", mem_write, 1'b0);
        step();
        reset = 1'b0;
        check("rstacc_rvalid", {cpu_rvalid, dbg_rvalid}, 2'b00);
        check("rstacc_cpu_rdata", cpu_rdata, 16'h0);
        check("rstacc_mem_addr", mem_addr, 8'h0);
        step();
        check("rstacc_idle", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid}, 4'b0000);
        run_single(1'b0, 1'b0, 8'd3, 16'h0, 16'h5555, "post_rst_read");

        // Randomized traffic against a transaction-level model
        do_reset();
        for (int a = 0; a < 16; a++) begin
            run_single(a[0], 1'b1, a[7:0], 16'($urandom), 16'h0, $sformatf("preload%0d", a));
        end
        exp_last   = 1'b1;
        exp_cpu_rd = 16'h0;
        exp_dbg_rd = 16'h0;
        cp = 1'b0;
        dp = 1'b0;
        for (int r = 0; r < 120; r++) begin
            if (!cp && !dp && $urandom_range(0, 4) == 0) begin
                step();
                check($sformatf("rnd%0d_idle", r), {cpu_gnt, dbg_gnt}, 2'b00);
                continue;
            end
            sel = $urandom_range(0, 3);
            if (!cp && (sel == 0 || sel == 2 || (!dp && sel == 3))) begin
                cp = 1'b1; cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
            end
            if (!dp && (sel == 1 || sel == 2)) begin
                dp = 1'b1; dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 8'($urandom_range(0, 15)); dbg_wdata = 16'($urandom);
            end
            if (cp && dp) begin
`ifdef ARB_ROUND_ROBIN_EN
                ew = ~exp_last;
`else
                ew = 1'b0;
`endif
            end else begin
                ew = dp;
            end
            exp_last = ew;
            w_we    = ew ? dbg_we    : cpu_we;
            w_addr  = ew ? dbg_addr  : cpu_addr;
            w_wdata = ew ? dbg_wdata : cpu_wdata;
            step();
            check($sformatf("rnd%0d_gnt", r), {cpu_gnt, dbg_gnt}, ew ? 2'b01 : 2'b10);
            check($sformatf("rnd%0d_mem_write", r), mem_write, w_we);
            check($sformatf("rnd%0d_mem_addr", r), mem_addr, w_addr);
            if (ew) begin dbg_req = 1'b0; dp = 1'b0; end
            else    begin cpu_req = 1'b0; cp = 1'b0; end
            step();
            check($sformatf("rnd%0d_rvalid", r), {cpu_rvalid, dbg_rvalid},
                  w_we ? 2'b00 : (ew ? 2'b01 : 2'b10));
            if (w_we) ref_mem[w_addr] = w_wdata;
            else if (ew) exp_dbg_rd = ref_mem[w_addr];
            else exp_cpu_rd = ref_mem[w_addr];
            check($sformatf("rnd%0d_cpu_rdata", r), cpu_rdata, exp_cpu_rd);
            check($sformatf("rnd%0d_dbg_rdata", r), dbg_rdata, exp_dbg_rd);
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
